// File: rtl/mem_request_scheduler.sv
// mem_request_scheduler: arbitrates a CPU byte port, a video word port and periodic auto-refresh
// onto a single memory_controller read/write/refresh command port.
// Optional build macro MEM_SCHED_FAIRNESS_EN: adds a CPU anti-starvation counter and exposes the
// sticky refresh_overrun output. Without it the arbitration is strict priority and the overrun flag
// is kept internally only.
module mem_request_scheduler #(
    parameter int unsigned REFRESH_PERIOD = 840,
    parameter int unsigned REFRESH_URGENT = 4,
    parameter int unsigned READ_LATENCY   = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_req,
    input  logic        cpu_wr,
    input  logic [22:0] cpu_addr,
    input  logic [7:0]  cpu_wdata,
    output logic [7:0]  cpu_rdata,
    output logic        cpu_ack,
    input  logic        vid_req,
    input  logic [21:0] vid_addr,
    output logic [15:0] vid_rdata,
    output logic        vid_valid,
    output logic        mem_read,
    output logic        mem_write,
    output logic        mem_refresh,
    output logic [21:0] mem_addr,
    output logic [15:0] mem_din,
    output logic [1:0]  mem_wdm,
`ifdef MEM_SCHED_FAIRNESS_EN
    output logic        refresh_overrun,
`endif
    input  logic [15:0] mem_dout,
    input  logic        mem_busy,
    input  logic        mem_enabled
);

    localparam int unsigned RC_W   = (REFRESH_PERIOD > 1) ? $clog2(REFRESH_PERIOD) : 1;
    localparam int unsigned LAT_W  = $clog2(READ_LATENCY + 1);
    localparam int unsigned DEBT_W = 3;
    localparam logic [DEBT_W-1:0] DEBT_MAX = '1;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;
    typedef enum logic [1:0] {OP_CPU_RD, OP_CPU_WR, OP_VID, OP_REF} op_t;

    state_t              state_q, state_d;
    op_t                 op_q, op_d;
    logic                byte_sel_q, byte_sel_d;
    logic [LAT_W-1:0]    lat_cnt_q, lat_cnt_d;
    logic [RC_W-1:0]     ref_cnt_q, ref_cnt_d;
    logic [DEBT_W-1:0]   debt_q, debt_d;
    logic                overrun_q, overrun_d;

    logic                mem_read_q, mem_read_d;
    logic                mem_write_q, mem_write_d;
    logic                mem_refresh_q, mem_refresh_d;
    logic [21:0]         mem_addr_q, mem_addr_d;
    logic [15:0]         mem_din_q, mem_din_d;
    logic [1:0]          mem_wdm_q, mem_wdm_d;
    logic [7:0]          cpu_rdata_q, cpu_rdata_d;
    logic                cpu_ack_q, cpu_ack_d;
    logic [15:0]         vid_rdata_q, vid_rdata_d;
    logic                vid_valid_q, vid_valid_d;

    logic                ref_wrap;
    logic                grant_ref, grant_vid, grant_cpu;
    logic                arb_open, in_done, vid_ok, cpu_ok, low_ref_ok, urgent, fair_force;

`ifdef MEM_SCHED_FAIRNESS_EN
    logic [2:0]          fair_cnt_q, fair_cnt_d;
`endif

    // Arbitration; in DONE the client being acknowledged still holds a stale request, so it is masked,
    // and non-urgent refresh only chains onto a previous refresh (a just-served client gets the next slot).
    always_comb begin
        arb_open   = mem_enabled && !mem_busy && (state_q == S_IDLE || state_q == S_DONE);
        in_done    = (state_q == S_DONE);
        vid_ok     = vid_req && !(in_done && op_q == OP_VID);
        cpu_ok     = cpu_req && !(in_done && (op_q == OP_CPU_RD || op_q == OP_CPU_WR));
        low_ref_ok = (debt_q != '0) && (!in_done || op_q == OP_REF);
        urgent     = (debt_q >= DEBT_W'(REFRESH_URGENT));
`ifdef MEM_SCHED_FAIRNESS_EN
        fair_force = (fair_cnt_q >= 3'd4) && cpu_ok;
`else
        fair_force = 1'b0;
`endif
        grant_ref  = 1'b0;
        grant_vid  = 1'b0;
        grant_cpu  = 1'b0;
        if (arb_open) begin
            if (urgent)          grant_ref = 1'b1;
            else if (fair_force) grant_cpu = 1'b1;
            else if (vid_ok)     grant_vid = 1'b1;
            else if (cpu_ok)     grant_cpu = 1'b1;
            else if (low_ref_ok) grant_ref = 1'b1;
        end
    end

    // Refresh credit timer and debt; a wrap and a granted refresh in the same cycle cancel out.
    always_comb begin
        ref_wrap  = (ref_cnt_q == '0);
        ref_cnt_d = ref_wrap ? RC_W'(REFRESH_PERIOD - 1) : ref_cnt_q - RC_W'(1);
        debt_d    = debt_q;
        overrun_d = overrun_q;
        if (ref_wrap && !grant_ref) begin
            if (debt_q == DEBT_MAX) overrun_d = 1'b1;
            else                    debt_d    = debt_q + DEBT_W'(1);
        end else if (!ref_wrap && grant_ref) begin
            debt_d = debt_q - DEBT_W'(1);
        end
    end

`ifdef MEM_SCHED_FAIRNESS_EN
    // Consecutive video grants while the CPU waits; at 4 the CPU is forced in next.
    always_comb begin
        fair_cnt_d = fair_cnt_q;
        if (!cpu_req || grant_cpu)             fair_cnt_d = 3'd0;
        else if (grant_vid && fair_cnt_q < 3'd4) fair_cnt_d = fair_cnt_q + 3'd1;
    end
`endif

    // Transaction FSM: latch request at grant, pulse command, count latency, capture data, acknowledge.
    always_comb begin
        state_d       = state_q;
        op_d          = op_q;
        byte_sel_d    = byte_sel_q;
        lat_cnt_d     = lat_cnt_q;
        mem_read_d    = 1'b0;
        mem_write_d   = 1'b0;
        mem_refresh_d = 1'b0;
        mem_addr_d    = mem_addr_q;
        mem_din_d     = mem_din_q;
        mem_wdm_d     = mem_wdm_q;
        cpu_rdata_d   = cpu_rdata_q;
        cpu_ack_d     = 1'b0;
        vid_rdata_d   = vid_rdata_q;
        vid_valid_d   = 1'b0;
        case (state_q)
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                if (grant_ref) begin
                    state_d       = S_ISSUE;
                    op_d          = OP_REF;
                    mem_refresh_d = 1'b1;
                    mem_addr_d    = '0;
                    mem_din_d     = '0;
                    mem_wdm_d     = 2'b11;
                end else if (grant_vid) begin
                    state_d    = S_ISSUE;
                    op_d       = OP_VID;
                    mem_read_d = 1'b1;
                    mem_addr_d = vid_addr;
                    mem_din_d  = '0;
                    mem_wdm_d  = 2'b11;
                end else if (grant_cpu) begin
                    state_d     = S_ISSUE;
                    op_d        = cpu_wr ? OP_CPU_WR : OP_CPU_RD;
                    byte_sel_d  = cpu_addr[0];
                    mem_read_d  = !cpu_wr;
                    mem_write_d = cpu_wr;
                    mem_addr_d  = cpu_addr[22:1];
                    mem_din_d   = {cpu_wdata, cpu_wdata};
                    mem_wdm_d   = cpu_wr ? (cpu_addr[0] ? 2'b10 : 2'b01) : 2'b11;
                end
            end
            S_ISSUE: begin
                state_d   = S_WAIT;
                lat_cnt_d = LAT_W'(1);
            end
            S_WAIT: begin
                if (lat_cnt_q == LAT_W'(READ_LATENCY)) begin
                    state_d = S_DONE;
                    case (op_q)
                        OP_CPU_RD: begin
                            cpu_rdata_d = byte_sel_q ? mem_dout[15:8] : mem_dout[7:0];
                            cpu_ack_d   = 1'b1;
                        end
                        OP_CPU_WR: cpu_ack_d = 1'b1;
                        OP_VID: begin
                            vid_rdata_d = mem_dout;
                            vid_valid_d = 1'b1;
                        end
                        default: ;
                    endcase
                end else begin
                    lat_cnt_d = lat_cnt_q + LAT_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            op_q          <= OP_REF;
            byte_sel_q    <= 1'b0;
            lat_cnt_q     <= '0;
            ref_cnt_q     <= RC_W'(REFRESH_PERIOD - 1);
            debt_q        <= '0;
            overrun_q     <= 1'b0;
            mem_read_q    <= 1'b0;
            mem_write_q   <= 1'b0;
            mem_refresh_q <= 1'b0;
            mem_addr_q    <= '0;
            mem_din_q     <= '0;
            mem_wdm_q     <= '0;
            cpu_rdata_q   <= '0;
            cpu_ack_q     <= 1'b0;
            vid_rdata_q   <= '0;
            vid_valid_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            op_q          <= op_d;
            byte_sel_q    <= byte_sel_d;
            lat_cnt_q     <= lat_cnt_d;
            ref_cnt_q     <= ref_cnt_d;
            debt_q        <= debt_d;
            overrun_q     <= overrun_d;
            mem_read_q    <= mem_read_d;
            mem_write_q   <= mem_write_d;
            mem_refresh_q <= mem_refresh_d;
            mem_addr_q    <= mem_addr_d;
            mem_din_q     <= mem_din_d;
            mem_wdm_q     <= mem_wdm_d;
            cpu_rdata_q   <= cpu_rdata_d;
            cpu_ack_q     <= cpu_ack_d;
            vid_rdata_q   <= vid_rdata_d;
            vid_valid_q   <= vid_valid_d;
        end
    end

`ifdef MEM_SCHED_FAIRNESS_EN
    // Fairness counter register.
    always_ff @(posedge clk) begin
        if (reset) fair_cnt_q <= 3'd0;
        else       fair_cnt_q <= fair_cnt_d;
    end

    assign refresh_overrun = overrun_q;
`endif

    assign mem_read    = mem_read_q;
    assign mem_write   = mem_write_q;
    assign mem_refresh = mem_refresh_q;
    assign mem_addr    = mem_addr_q;
    assign mem_din     = mem_din_q;
    assign mem_wdm     = mem_wdm_q;
    assign cpu_rdata   = cpu_rdata_q;
    assign cpu_ack     = cpu_ack_q;
    assign vid_rdata   = vid_rdata_q;
    assign vid_valid   = vid_valid_q;

endmodule

// File: tb/tb_mem_request_scheduler.sv
// Directed testbench for mem_request_scheduler with a fixed-latency memory read model.
module tb_mem_request_scheduler;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_req, cpu_wr;
    logic [22:0] cpu_addr;
    logic [7:0]  cpu_wdata, cpu_rdata;
    logic        cpu_ack;
    logic        vid_req;
    logic [21:0] vid_addr;
    logic [15:0] vid_rdata;
    logic        vid_valid;
    logic        mem_read, mem_write, mem_refresh;
    logic [21:0] mem_addr;
    logic [15:0] mem_din;
    logic [1:0]  mem_wdm;
    logic [15:0] mem_dout;
    logic        mem_busy, mem_enabled;
`ifdef MEM_SCHED_FAIRNESS_EN
    logic        refresh_overrun;
`endif

    mem_request_scheduler dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
        .vid_req(vid_req), .vid_addr(vid_addr), .vid_rdata(vid_rdata), .vid_valid(vid_valid),
        .mem_read(mem_read), .mem_write(mem_write), .mem_refresh(mem_refresh),
        .mem_addr(mem_addr), .mem_din(mem_din), .mem_wdm(mem_wdm),
`ifdef MEM_SCHED_FAIRNESS_EN
        .refresh_overrun(refresh_overrun),
`endif
        .mem_dout(mem_dout), .mem_busy(mem_busy), .mem_enabled(mem_enabled)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Memory model: data for a read issued in cycle T is presented only during cycle T+4.
    logic [15:0] rd_word = 16'h0000;
    logic [3:0]  rd_pipe = 4'b0000;
    always @(posedge clk) rd_pipe <= {rd_pipe[2:0], mem_read};
    assign mem_dout = rd_pipe[3] ? rd_word : 16'hDEAD;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Event log filled by observe()
    int t_rd, t_rd2, t_wr, t_ref, t_ref_last, t_ack, t_vv;
    int n_rd, n_wr, n_ref, n_ack, n_vv, n_multi, gap_min, gap_max;
    logic [21:0] addr1, addr2;
    logic [15:0] din1, vrdata1;
    logic [1:0]  wdm1;
    logic [7:0]  rdata1;
    int t0;

    task automatic clear_log();
        t_rd = -1; t_rd2 = -1; t_wr = -1; t_ref = -1; t_ref_last = -1; t_ack = -1; t_vv = -1;
        n_rd = 0; n_wr = 0; n_ref = 0; n_ack = 0; n_vv = 0; n_multi = 0;
        gap_min = 1 << 30; gap_max = 0;
        addr1 = '0; addr2 = '0; din1 = '0; vrdata1 = '0; wdm1 = '0; rdata1 = '0;
    endtask

    // Sample outputs on falling edges for ncyc cycles; optionally drop a request when it is acked.
    task automatic observe(input int ncyc, input bit drop);
        for (int i = 0; i < ncyc; i++) begin
            @(negedge clk);
            if (int'(mem_read) + int'(mem_write) + int'(mem_refresh) > 1) n_multi++;
            if (mem_read) begin
                n_rd++;
                if (t_rd < 0) begin t_rd = cyc; addr1 = mem_addr; wdm1 = mem_wdm; end
                else if (t_rd2 < 0) begin t_rd2 = cyc; addr2 = mem_addr; end
            end
            if (mem_write) begin
                n_wr++;
                if (t_wr < 0) begin t_wr = cyc; addr1 = mem_addr; din1 = mem_din; wdm1 = mem_wdm; end
            end
            if (mem_refresh) begin
                n_ref++;
                if (t_ref < 0) t_ref = cyc;
                if (t_ref_last >= 0) begin
                    if (cyc - t_ref_last < gap_min) gap_min = cyc - t_ref_last;
                    if (cyc - t_ref_last > gap_max) gap_max = cyc - t_ref_last;
                end
                t_ref_last = cyc;
            end
            if (cpu_ack) begin
                n_ack++; t_ack = cyc; rdata1 = cpu_rdata;
                if (drop) cpu_req = 1'b0;
            end
            if (vid_valid) begin
                n_vv++; if (t_vv < 0) t_vv = cyc; vrdata1 = vid_rdata;
                if (drop) vid_req = 1'b0;
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; cpu_req = 1'b0; vid_req = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        t0 = cyc;
    endtask

    task automatic cpu_start(input bit wr, input logic [22:0] a, input logic [7:0] wd);
        @(negedge clk);
        cpu_wr = wr; cpu_addr = a; cpu_wdata = wd; cpu_req = 1'b1;
    endtask

    bit found;

    initial begin
        reset = 1'b1; cpu_req = 1'b0; cpu_wr = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        vid_req = 1'b0; vid_addr = '0; mem_busy = 1'b0; mem_enabled = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_mem_side", 64'({mem_read, mem_write, mem_refresh, mem_addr, mem_din, mem_wdm}), 64'd0);
        check("rst_client_side", 64'({cpu_rdata, cpu_ack, vid_rdata, vid_valid}), 64'd0);
        reset = 1'b0;

        // CPU write, odd byte
        cpu_start(1'b1, 23'h000003, 8'hA5);
        clear_log(); observe(12, 1'b1);
        check("t1_nwrite", 64'(n_wr), 64'd1);
        check("t1_addr", 64'(addr1), 64'h1);
        check("t1_din", 64'(din1), 64'hA5A5);
        check("t1_wdm", 64'(wdm1), 64'b10);
        check("t1_ack_lat", 64'(t_ack - t_wr), 64'd5);
        check("t1_nack", 64'(n_ack), 64'd1);

        // CPU read, even then odd byte
        rd_word = 16'h1234;
        cpu_start(1'b0, 23'h000010, 8'h00);
        clear_log(); observe(12, 1'b1);
        check("t2_addr", 64'(addr1), 64'h8);
        check("t2_wdm", 64'(wdm1), 64'b11);
        check("t2_ack_lat", 64'(t_ack - t_rd), 64'd5);
        check("t2_rdata_even", 64'(rdata1), 64'h34);
        check("t2_no_vid", 64'(n_vv), 64'd0);
        cpu_start(1'b0, 23'h000011, 8'h00);
        clear_log(); observe(12, 1'b1);
        check("t2_rdata_odd", 64'(rdata1), 64'h12);

        // Simultaneous CPU + video: video first, CPU issued six cycles later
        rd_word = 16'hBEEF;
        @(negedge clk);
        cpu_wr = 1'b0; cpu_addr = 23'h000020; cpu_req = 1'b1;
        vid_addr = 22'h000155; vid_req = 1'b1;
        clear_log(); observe(20, 1'b1);
        check("t3_first_is_vid", 64'(addr1), 64'h155);
        check("t3_vid_lat", 64'(t_vv - t_rd), 64'd5);
        check("t3_vid_data", 64'(vrdata1), 64'hBEEF);
        check("t3_cpu_gap", 64'(t_rd2 - t_rd), 64'd6);
        check("t3_cpu_addr", 64'(addr2), 64'h10);
        check("t3_cpu_data", 64'(rdata1), 64'hEF);
        check("t3_nack", 64'(n_ack), 64'd1);

        // Controller busy holds off grants
        rd_word = 16'hCAFE;
        mem_busy = 1'b1;
        cpu_start(1'b0, 23'h000041, 8'h00);
        clear_log(); observe(8, 1'b1);
        check("busy_no_grant", 64'(n_rd), 64'd0);
        mem_busy = 1'b0;
        clear_log(); observe(10, 1'b1);
        check("busy_then_grant", 64'(n_rd), 64'd1);
        check("busy_rdata", 64'(rdata1), 64'hCA);

        // Reset at T+2 of a read abandons it
        cpu_start(1'b0, 23'h000022, 8'h00);
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            @(negedge clk);
            if (mem_read) found = 1'b1;
        end
        check("t6_issue_seen", 64'(found), 64'd1);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("t6_mem_side_zero", 64'({mem_read, mem_write, mem_refresh, mem_addr, mem_din, mem_wdm}), 64'd0);
        check("t6_client_zero", 64'({cpu_rdata, cpu_ack, vid_rdata, vid_valid}), 64'd0);
        reset = 1'b0; cpu_req = 1'b0;
        clear_log(); observe(10, 1'b1);
        check("t6_no_ack", 64'(n_ack), 64'd0);

        // Idle refresh cadence
        do_reset();
        clear_log(); observe(1700, 1'b1);
        check("t4_idle_nref", 64'(n_ref), 64'd2);
        check("t4_idle_first", 64'((t_ref - t0) >= 840 && (t_ref - t0) <= 846), 64'd1);
        check("t4_idle_gap", 64'(gap_max), 64'd840);

        // Continuous video: refresh only once debt reaches the urgent level
        do_reset();
        vid_addr = 22'h000200; vid_req = 1'b1;
        clear_log(); observe(3460, 1'b0);
        vid_req = 1'b0;
        check("t4_vid_nref", 64'(n_ref), 64'd1);
        check("t4_vid_preempt_time", 64'((t_ref - t0) >= 3361 && (t_ref - t0) <= 3370), 64'd1);
        check("t4_vid_flowing", 64'(n_vv >= 450), 64'd1);
        observe(10, 1'b1);

        // Controller disabled: debt saturates, then drains back-to-back
        do_reset();
        mem_enabled = 1'b0;
        cpu_wr = 1'b0; cpu_addr = 23'h000000; cpu_req = 1'b1;
        clear_log(); observe(9 * 840 + 10, 1'b1);
        check("t5_disabled_nref", 64'(n_ref), 64'd0);
        check("t5_disabled_nrd", 64'(n_rd), 64'd0);
        cpu_req = 1'b0;
        mem_enabled = 1'b1;
        clear_log(); observe(60, 1'b1);
        check("t5_nref", 64'(n_ref), 64'd7);
        check("t5_gap_min", 64'(gap_min), 64'd6);
        check("t5_gap_max", 64'(gap_max), 64'd6);
`ifdef MEM_SCHED_FAIRNESS_EN
        check("t5_overrun", 64'(refresh_overrun), 64'd1);
`endif

        check("single_cmd_pulse", 64'(n_multi), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
